pnml_cell_sequencer: RTL and testbench

Controller that sequences a row of pNML NAND/NOR storage cells from a single system clock. It accepts one command at a time over a valid/ready interface: NAND evaluate, NOR evaluate, shift forward N, or shift backward N. It drives the shared cell control lines `nand_nor_sel`, `bz_s`, `bz_m`, `current_s` and `current_m` as glitch-free, registered, non-overlapping strobes. It sits between the core-side command logic and the cell array.

---
 rtl/pnml_cell_sequencer.sv | 146 ++++++++++++++
 tb/tb_pnml_cell_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pnml_cell_sequencer.sv
// Sequencer for a row of pNML NAND/NOR cells: turns one command at a time into
// registered, non-overlapping bz/current strobes with stable selects around them.
module pnml_cell_sequencer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int CNT_W     = 4
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic             nand_nor_sel,
    output logic             bz_s,
    output logic             bz_m,
    output logic             current_s,
    output logic             current_m,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int MAXP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int TW   = $clog2(MAXP + 1);

    typedef enum logic [3:0] {
        IDLE, EV_SET0, EV_PUL0, EV_SET1, EV_PUL1, EV_END, SH_SET, SH_PUL, SH_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abrt_q, abrt_d, abort_now;
    logic             sel_q, sel_d, cur_s_q, cur_s_d;
    logic             bz_s_q, bz_m_q, cur_m_q, busy_q, done_q, aborted_q, ready_q;
    logic             done_d, aborted_d;

    function automatic logic [TW-1:0] phase_len(input state_t s);
        if (s == EV_PUL0 || s == EV_PUL1 || s == SH_PUL)
            return TW'(PULSE_CYC);
        return TW'(SETUP_CYC);
    endfunction

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        abrt_d    = abrt_q;
        sel_d     = sel_q;
        cur_s_d   = cur_s_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        abort_now = abrt_q | abort;

        if (state_q == IDLE) begin
            abrt_d = 1'b0;
            if (cmd_valid && ready_q) begin
                if (!cmd_op[1]) begin
                    sel_d   = ~cmd_op[0];
                    state_d = EV_SET0;
                end else begin
                    cur_s_d = cmd_op[0];
                    cnt_d   = cmd_count;
                    // A zero-length shift completes without ever leaving IDLE
                    if (cmd_count == '0)
                        done_d = 1'b1;
                    else
                        state_d = SH_SET;
                end
            end
        end else begin
            abrt_d = abort_now;
            if (timer_q == TW'(1)) begin
                // Once abort is seen, pulses run out and lead into a low phase, low phases exit
                case (state_q)
                    EV_SET0: state_d = abort_now ? IDLE : EV_PUL0;
                    EV_PUL0: state_d = abort_now ? EV_END : EV_SET1;
                    EV_SET1: state_d = abort_now ? IDLE : EV_PUL1;
                    EV_PUL1: state_d = EV_END;
                    EV_END:  state_d = IDLE;
                    SH_SET:  state_d = abort_now ? IDLE : SH_PUL;
                    SH_PUL:  state_d = SH_GAP;
                    SH_GAP: begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        state_d = (abort_now || cnt_q <= CNT_W'(1)) ? IDLE : SH_PUL;
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                timer_d = timer_q - TW'(1);
            end
            if (state_d == IDLE) begin
                done_d    = 1'b1;
                aborted_d = abort_now;
            end
        end

        if (state_d != state_q)
            timer_d = phase_len(state_d);
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            cnt_q     <= '0;
            abrt_q    <= 1'b0;
            sel_q     <= 1'b0;
            cur_s_q   <= 1'b0;
            bz_s_q    <= 1'b0;
            bz_m_q    <= 1'b0;
            cur_m_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            abrt_q    <= abrt_d;
            sel_q     <= sel_d;
            cur_s_q   <= cur_s_d;
            bz_s_q    <= (state_d == EV_SET1) || (state_d == EV_PUL1);
            bz_m_q    <= (state_d == EV_PUL0) || (state_d == EV_PUL1);
            cur_m_q   <= (state_d == SH_PUL);
            busy_q    <= (state_d != IDLE);
            done_q    <= done_d;
            aborted_q <= aborted_d;
            ready_q   <= (state_d == IDLE);
        end
    end

    assign cmd_ready    = ready_q;
    assign nand_nor_sel = sel_q;
    assign bz_s         = bz_s_q;
    assign bz_m         = bz_m_q;
    assign current_s    = cur_s_q;
    assign current_m    = cur_m_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_pnml_cell_sequencer.sv
// Directed bench for pnml_cell_sequencer: per-cycle vector table plus abort and reset sequences.
module tb_pnml_cell_sequencer;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       v1 = 1'b0, ab1 = 1'b0;
    logic [1:0] op1 = 2'b00;
    logic [3:0] cnt1 = 4'd0;
    logic rdy1, sel1, bzs1, bzm1, cs1, cm1, busy1, done1, abd1;

    pnml_cell_sequencer #(.SETUP_CYC(1), .PULSE_CYC(1), .CNT_W(4)) dut (
        .clk_i(clk), .rstn(rstn), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_op(op1),
        .cmd_count(cnt1), .abort(ab1), .nand_nor_sel(sel1), .bz_s(bzs1), .bz_m(bzm1),
        .current_s(cs1), .current_m(cm1), .busy(busy1), .done(done1), .aborted(abd1));

    // Long-pulse instance for the abort-in-pulse sequence
    logic       v2 = 1'b0, ab2 = 1'b0;
    logic [1:0] op2 = 2'b00;
    logic [3:0] cnt2 = 4'd0;
    logic rdy2, sel2, bzs2, bzm2, cs2, cm2, busy2, done2, abd2;

    pnml_cell_sequencer #(.SETUP_CYC(2), .PULSE_CYC(3), .CNT_W(4)) dut2 (
        .clk_i(clk), .rstn(rstn), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_op(op2),
        .cmd_count(cnt2), .abort(ab2), .nand_nor_sel(sel2), .bz_s(bzs2), .bz_m(bzm2),
        .current_s(cs2), .current_m(cm2), .busy(busy2), .done(done2), .aborted(abd2));

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [3:0] cnt;
        logic       ab;
        logic [8:0] exp;  // {ready,busy,done,aborted,sel,bz_s,bz_m,cur_s,cur_m}
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic v, input logic [1:0] op, input logic [3:0] cnt,
                       input logic ab, input logic [8:0] exp);
        vec_t r;
        r.v = v; r.op = op; r.cnt = cnt; r.ab = ab; r.exp = exp;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] outs1();
        return {rdy1, busy1, done1, abd1, sel1, bzs1, bzm1, cs1, cm1};
    endfunction

    initial begin
        // NAND eval from reset
        add(1, 2'b00, 0, 0, 9'b1_0_0_0_0_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_1_0_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_1_0_0_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_1_1_0_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b1_0_1_0_1_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b1_0_0_0_1_0_0_0_0);
        // Shift backward 3
        add(1, 2'b11, 3, 0, 9'b1_0_0_0_1_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_0_1_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_0_1_1);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_0_1_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_0_1_1);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_0_1_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_0_1_1);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_1_0_0_1_0);
        add(0, 2'b00, 0, 0, 9'b1_0_1_0_1_0_0_1_0);
        add(0, 2'b00, 0, 0, 9'b1_0_0_0_1_0_0_1_0);
        // Shift forward 0
        add(1, 2'b10, 0, 0, 9'b1_0_0_0_1_0_0_1_0);
        add(0, 2'b00, 0, 0, 9'b1_0_1_0_1_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b1_0_0_0_1_0_0_0_0);
        // NOR eval, valid held, shift forward 1 accepted in the done cycle
        add(1, 2'b01, 0, 0, 9'b1_0_0_0_1_0_0_0_0);
        add(1, 2'b10, 1, 0, 9'b0_1_0_0_0_0_0_0_0);
        add(1, 2'b10, 1, 0, 9'b0_1_0_0_0_0_1_0_0);
        add(1, 2'b10, 1, 0, 9'b0_1_0_0_0_1_0_0_0);
        add(1, 2'b10, 1, 0, 9'b0_1_0_0_0_1_1_0_0);
        add(1, 2'b10, 1, 0, 9'b0_1_0_0_0_0_0_0_0);
        add(1, 2'b10, 1, 0, 9'b1_0_1_0_0_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_0_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_0_0_0_0_1);
        add(0, 2'b00, 0, 0, 9'b0_1_0_0_0_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b1_0_1_0_0_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b1_0_0_0_0_0_0_0_0);
        // NAND eval aborted in its first low phase, then abort while idle
        add(1, 2'b00, 0, 0, 9'b1_0_0_0_0_0_0_0_0);
        add(0, 2'b00, 0, 1, 9'b0_1_0_0_1_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b1_0_1_1_1_0_0_0_0);
        add(0, 2'b00, 0, 1, 9'b1_0_0_0_1_0_0_0_0);
        add(0, 2'b00, 0, 0, 9'b1_0_0_0_1_0_0_0_0);

        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step();

        foreach (vecs[i]) begin
            chk($sformatf("vec[%0d]", i), 32'(outs1()), 32'(vecs[i].exp));
            v1 = vecs[i].v; op1 = vecs[i].op; cnt1 = vecs[i].cnt; ab1 = vecs[i].ab;
            step();
        end
        v1 = 1'b0; ab1 = 1'b0;

        // Long-pulse NOR eval, abort in first bz_m cycle
        v2 = 1'b1; op2 = 2'b01;
        step();
        v2 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("ab_bzm[c%0d]", c), 32'(bzm2), 32'((c >= 3 && c <= 5) ? 1 : 0));
            chk($sformatf("ab_bzs[c%0d]", c), 32'(bzs2), 32'(0));
            chk($sformatf("ab_busy[c%0d]", c), 32'(busy2), 32'((c <= 7) ? 1 : 0));
            chk($sformatf("ab_done[c%0d]", c), 32'({done2, abd2}), 32'((c == 8) ? 3 : 0));
            ab2 = (c == 3);
            step();
        end
        ab2 = 1'b0;

        // Shift forward 5, reset after second current_m pulse
        v1 = 1'b1; op1 = 2'b10; cnt1 = 4'd5;
        step();
        v1 = 1'b0;
        repeat (3) step();
        chk("rst_pre_cm", 32'(cm1), 32'(1));
        step();
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_outs", 32'(outs1()), 32'(9'b1_0_0_0_0_0_0_0_0));
        repeat (2) step();
        chk("rst_held_outs", 32'(outs1()), 32'(9'b1_0_0_0_0_0_0_0_0));
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rst_nodone[%0d]", c), 32'({done1, busy1, cm1, rdy1}), 32'(4'b0001));
        end

        // A fresh NAND eval completes after reset
        v1 = 1'b1; op1 = 2'b00;
        step();
        v1 = 1'b0;
        begin
            int n = 1;
            while (!done1 && n < 20) begin
                step();
                n++;
            end
            chk("post_rst_done_latency", 32'(n), 32'(6));
            chk("post_rst_aborted", 32'({done1, abd1}), 32'(2'b10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
